decode_stage: RTL and testbench

Registered RV32I instruction decode stage with optional M-extension decode. It sits between fetch and execute. A 2-entry skid buffer gives full-throughput valid/ready handshaking on both sides. It resolves the full 4-bit ALU control, marks illegal instructions, and passes branch condition codes to execute instead of evaluating ALU flags in decode.

---
 rtl/decode_pkg.sv | 78 +++++++
 rtl/instr_decode_comb.sv | 124 ++++++++++++
 rtl/decode_stage.sv | 132 +++++++++++++
 tb/tb_decode_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode, ALU/immediate/result codes and control bundle for the RV32I decode stage
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_IMM = 2'd2;
  localparam logic [1:0] RES_PC4 = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_MAIN,
    ST_SKID
  } stage_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       reg_write;
    logic [2:0] imm_source;
    logic [2:0] load_ctrl;
    logic [1:0] store_ctrl;
    logic       src_a_in;
    logic       src_b_in;
    logic [1:0] result_source;
    logic       mem_write;
    logic       branch;
    logic [2:0] branch_cond;
    logic       jump;
    logic       jalr;
    logic [3:0] alu_ctrl;
    logic       is_mul_div;
    logic [2:0] mul_div_op;
    logic       illegal;
  } ctrl_t;

  // ALU op for the funct3 of an OP/OP_IMM instruction, ignoring funct7
  function automatic logic [3:0] alu_base(input logic [2:0] funct3);
    case (funct3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// rtl/instr_decode_comb.sv - combinational RV32I(+M) instruction word to control bundle decode
module instr_decode_comb
  import decode_pkg::*;
#(
  parameter int ENABLE_M = 0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl      = '0;
    legal     = 1'b1;
    ctrl.rd   = instr[11:7];
    ctrl.rs1  = instr[19:15];
    ctrl.rs2  = instr[24:20];
    case (opcode)
      OPC_LOAD: begin
        legal              = !(funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
        ctrl.imm_source    = IMM_I;
        ctrl.load_ctrl     = funct3;
        ctrl.src_a_in      = 1'b1;
        ctrl.src_b_in      = 1'b1;
        ctrl.result_source = RES_MEM;
        ctrl.reg_write     = 1'b1;
      end
      OPC_STORE: begin
        legal           = (funct3 <= 3'd2);
        ctrl.imm_source = IMM_S;
        ctrl.store_ctrl = funct3[1:0];
        ctrl.src_a_in   = 1'b1;
        ctrl.src_b_in   = 1'b1;
        ctrl.mem_write  = 1'b1;
      end
      OPC_OP: begin
        ctrl.src_a_in  = 1'b1;
        ctrl.reg_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          ctrl.alu_ctrl = alu_base(funct3);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)) begin
          ctrl.alu_ctrl = (funct3 == 3'd0) ? ALU_SUB : ALU_SRA;
        end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
          ctrl.is_mul_div = 1'b1;
          ctrl.mul_div_op = funct3;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        ctrl.imm_source = IMM_I;
        ctrl.src_a_in   = 1'b1;
        ctrl.src_b_in   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_ctrl   = alu_base(funct3);
        // Shift immediates reuse funct7 as an opcode extension; only SRAI may set bit 30
        if (funct3 == 3'd1) begin
          legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'd5) begin
          if (funct7 == 7'b0100000) ctrl.alu_ctrl = ALU_SRA;
          else if (funct7 != 7'b0000000) legal = 1'b0;
        end
      end
      OPC_LUI: begin
        ctrl.imm_source    = IMM_U;
        ctrl.src_a_in      = 1'b1;
        ctrl.src_b_in      = 1'b1;
        ctrl.result_source = RES_IMM;
        ctrl.reg_write     = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.imm_source = IMM_U;
        ctrl.src_b_in   = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OPC_BRANCH: begin
        legal            = !(funct3 == 3'd2 || funct3 == 3'd3);
        ctrl.imm_source  = IMM_B;
        ctrl.src_a_in    = 1'b1;
        ctrl.branch      = 1'b1;
        ctrl.branch_cond = funct3;
        ctrl.alu_ctrl    = ALU_SUB;
      end
      OPC_JAL: begin
        ctrl.imm_source    = IMM_J;
        ctrl.src_b_in      = 1'b1;
        ctrl.jump          = 1'b1;
        ctrl.result_source = RES_PC4;
        ctrl.reg_write     = 1'b1;
      end
      OPC_JALR: begin
        legal              = (funct3 == 3'd0);
        ctrl.imm_source    = IMM_I;
        ctrl.src_a_in      = 1'b1;
        ctrl.src_b_in      = 1'b1;
        ctrl.jump          = 1'b1;
        ctrl.jalr          = 1'b1;
        ctrl.result_source = RES_PC4;
        ctrl.reg_write     = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (ctrl.rd == 5'd0) ctrl.reg_write = 1'b0;

    // Illegal words still flow to execute so it can trap; only indices survive
    if (!legal || instr[1:0] != 2'b11) begin
      ctrl         = '0;
      ctrl.rd      = instr[11:7];
      ctrl.rs1     = instr[19:15];
      ctrl.rs2     = instr[24:20];
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with 2-entry skid buffer between fetch and execute
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_regWrite,
  output logic [2:0]      out_immSource,
  output logic [2:0]      out_loadCtrl,
  output logic [1:0]      out_storeCtrl,
  output logic            out_srcAIn,
  output logic            out_srcBIn,
  output logic [1:0]      out_resultSource,
  output logic            out_memWrite,
  output logic            out_branch,
  output logic [2:0]      out_branchCond,
  output logic            out_jump,
  output logic            out_jalr,
  output logic [3:0]      out_ALUCtrl,
  output logic            out_isMulDiv,
  output logic [2:0]      out_mulDivOp,
  output logic            out_illegal
);

  ctrl_t           dec;
  ctrl_t           main_ctrl;
  ctrl_t           skid_ctrl;
  logic [XLEN-1:0] main_pc;
  logic [XLEN-1:0] skid_pc;
  stage_state_e    state;
  logic            accept;
  logic            transfer;

  instr_decode_comb #(.ENABLE_M(ENABLE_M)) u_decode (
    .instr(in_instr),
    .ctrl (dec)
  );

  assign accept   = in_valid & in_ready;
  assign transfer = out_valid & out_ready;

  // Main always holds the oldest entry; skid only fills while main is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_pc   <= '0;
      skid_pc   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_ctrl <= dec;
            main_pc   <= in_pc;
            state     <= ST_MAIN;
            out_valid <= 1'b1;
          end
        end
        ST_MAIN: begin
          if (accept && transfer) begin
            main_ctrl <= dec;
            main_pc   <= in_pc;
          end else if (accept) begin
            skid_ctrl <= dec;
            skid_pc   <= in_pc;
            state     <= ST_SKID;
            in_ready  <= 1'b0;
          end else if (transfer) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_SKID: begin
          if (transfer) begin
            main_ctrl <= skid_ctrl;
            main_pc   <= skid_pc;
            state     <= ST_MAIN;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_pc           = main_pc;
  assign out_rd           = main_ctrl.rd;
  assign out_rs1          = main_ctrl.rs1;
  assign out_rs2          = main_ctrl.rs2;
  assign out_regWrite     = main_ctrl.reg_write;
  assign out_immSource    = main_ctrl.imm_source;
  assign out_loadCtrl     = main_ctrl.load_ctrl;
  assign out_storeCtrl    = main_ctrl.store_ctrl;
  assign out_srcAIn       = main_ctrl.src_a_in;
  assign out_srcBIn       = main_ctrl.src_b_in;
  assign out_resultSource = main_ctrl.result_source;
  assign out_memWrite     = main_ctrl.mem_write;
  assign out_branch       = main_ctrl.branch;
  assign out_branchCond   = main_ctrl.branch_cond;
  assign out_jump         = main_ctrl.jump;
  assign out_jalr         = main_ctrl.jalr;
  assign out_ALUCtrl      = main_ctrl.alu_ctrl;
  assign out_isMulDiv     = main_ctrl.is_mul_div;
  assign out_mulDivOp     = main_ctrl.mul_div_op;
  assign out_illegal      = main_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage, with and without M decode
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic        reg_write;
    logic [2:0]  imm_source, load_ctrl;
    logic [1:0]  store_ctrl;
    logic        src_a, src_b;
    logic [1:0]  result_source;
    logic        mem_write, branch;
    logic [2:0]  branch_cond;
    logic        jump, jalr;
    logic [3:0]  alu;
    logic        is_mul_div;
    logic [2:0]  mul_div_op;
    logic        illegal;
  } bundle_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready [2];
  logic        out_valid [2];
  logic [31:0] out_pc [2];
  logic [4:0]  out_rd [2], out_rs1 [2], out_rs2 [2];
  logic        out_regWrite [2], out_srcAIn [2], out_srcBIn [2], out_memWrite [2];
  logic        out_branch [2], out_jump [2], out_jalr [2], out_isMulDiv [2], out_illegal [2];
  logic [2:0]  out_immSource [2], out_loadCtrl [2], out_branchCond [2], out_mulDivOp [2];
  logic [1:0]  out_storeCtrl [2], out_resultSource [2];
  logic [3:0]  out_ALUCtrl [2];

  int checks = 0;
  int failures = 0;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_stage #(.XLEN(32), .ENABLE_M(g)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready[g]), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid[g]), .out_ready(out_ready), .out_pc(out_pc[g]),
      .out_rd(out_rd[g]), .out_rs1(out_rs1[g]), .out_rs2(out_rs2[g]),
      .out_regWrite(out_regWrite[g]), .out_immSource(out_immSource[g]),
      .out_loadCtrl(out_loadCtrl[g]), .out_storeCtrl(out_storeCtrl[g]),
      .out_srcAIn(out_srcAIn[g]), .out_srcBIn(out_srcBIn[g]),
      .out_resultSource(out_resultSource[g]), .out_memWrite(out_memWrite[g]),
      .out_branch(out_branch[g]), .out_branchCond(out_branchCond[g]),
      .out_jump(out_jump[g]), .out_jalr(out_jalr[g]), .out_ALUCtrl(out_ALUCtrl[g]),
      .out_isMulDiv(out_isMulDiv[g]), .out_mulDivOp(out_mulDivOp[g]),
      .out_illegal(out_illegal[g])
    );
  end

  function automatic bundle_t obs(int g);
    bundle_t b;
    b.pc = out_pc[g]; b.rd = out_rd[g]; b.rs1 = out_rs1[g]; b.rs2 = out_rs2[g];
    b.reg_write = out_regWrite[g]; b.imm_source = out_immSource[g];
    b.load_ctrl = out_loadCtrl[g]; b.store_ctrl = out_storeCtrl[g];
    b.src_a = out_srcAIn[g]; b.src_b = out_srcBIn[g]; b.result_source = out_resultSource[g];
    b.mem_write = out_memWrite[g]; b.branch = out_branch[g]; b.branch_cond = out_branchCond[g];
    b.jump = out_jump[g]; b.jalr = out_jalr[g]; b.alu = out_ALUCtrl[g];
    b.is_mul_div = out_isMulDiv[g]; b.mul_div_op = out_mulDivOp[g]; b.illegal = out_illegal[g];
    return b;
  endfunction

  // Reference decode built straight from the instruction-set rules
  function automatic bundle_t ref_decode(logic [31:0] w, logic [31:0] pc, int en_m);
    int alu_tbl [8] = '{0, 5, 4, 6, 7, 8, 3, 2};
    bundle_t b = '0;
    bit ok = 1;
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    b.pc = pc; b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20];
    case (w[6:0])
      7'h03: begin ok = !(f3 inside {3'd3, 3'd6, 3'd7}); b.load_ctrl = f3; b.src_a = 1; b.src_b = 1; b.result_source = 1; b.reg_write = 1; end
      7'h23: begin ok = (f3 <= 2); b.imm_source = 1; b.store_ctrl = f3[1:0]; b.src_a = 1; b.src_b = 1; b.mem_write = 1; end
      7'h33: begin
        b.src_a = 1; b.reg_write = 1;
        if (f7 == 7'h00) b.alu = 4'(alu_tbl[f3]);
        else if (f7 == 7'h20 && f3 == 0) b.alu = 1;
        else if (f7 == 7'h20 && f3 == 5) b.alu = 9;
        else if (f7 == 7'h01 && en_m == 1) begin b.is_mul_div = 1; b.mul_div_op = f3; end
        else ok = 0;
      end
      7'h13: begin
        b.src_a = 1; b.src_b = 1; b.reg_write = 1; b.alu = 4'(alu_tbl[f3]);
        if (f3 == 1) ok = (f7 == 7'h00);
        if (f3 == 5) begin if (f7 == 7'h20) b.alu = 9; else ok = (f7 == 7'h00); end
      end
      7'h37: begin b.imm_source = 4; b.result_source = 2; b.src_a = 1; b.src_b = 1; b.reg_write = 1; end
      7'h17: begin b.imm_source = 4; b.src_b = 1; b.reg_write = 1; end
      7'h63: begin ok = !(f3 inside {3'd2, 3'd3}); b.imm_source = 2; b.src_a = 1; b.branch = 1; b.branch_cond = f3; b.alu = 1; end
      7'h6F: begin b.imm_source = 3; b.src_b = 1; b.jump = 1; b.result_source = 3; b.reg_write = 1; end
      7'h67: begin ok = (f3 == 0); b.src_a = 1; b.src_b = 1; b.jump = 1; b.jalr = 1; b.result_source = 3; b.reg_write = 1; end
      default: ok = 0;
    endcase
    if (b.rd == 0) b.reg_write = 0;
    if (!ok) begin
      b = '0; b.pc = pc; b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.illegal = 1;
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    logic [6:0] f7s [3] = '{7'h00, 7'h20, 7'h01};
    logic [31:0] w = $urandom;
    int r = $urandom_range(0, 9);
    if (r < 9) w[6:0] = ops[r];
    if ($urandom_range(0, 1) == 1) w[31:25] = f7s[$urandom_range(0, 2)];
    return w;
  endfunction

  // One clock edge; the queue model follows the handshake rules of the stage
  task automatic tick();
    bit acc, xfr;
    acc = in_valid && q.size() < 2;
    xfr = q.size() > 0 && out_ready;
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (xfr) void'(q.pop_front());
      if (acc) q.push_back({in_instr, in_pc});
    end
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (out_valid[g] !== 1'b0 || in_ready[g] !== 1'b1 || obs(g) !== '0) begin
        failures++; $display("FAIL reset_initial dut%0d valid=%b ready=%b bundle=%h want 0/1/0", g, out_valid[g], in_ready[g], obs(g));
      end
    end
    @(negedge clk) rst = 0;
    in_valid = 1; in_instr = 32'h00A00093; in_pc = 32'h40;
    tick();
    in_instr = 32'h0000A103; in_pc = 32'h44;
    tick();
    in_valid = 0;
    checks++;
    if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
      failures++; $display("FAIL reset_fill_skid ready=%b valid=%b want 0/1", in_ready[0], out_valid[0]);
    end
    #2 rst = 1;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (out_valid[g] !== 1'b0 || in_ready[g] !== 1'b1 || obs(g) !== '0) begin
        failures++; $display("FAIL reset_midstream dut%0d valid=%b ready=%b bundle=%h want 0/1/0", g, out_valid[g], in_ready[g], obs(g));
      end
    end
    q.delete();
    @(negedge clk) rst = 0;
  endtask

  task automatic test_sub();
    in_valid = 1; in_instr = 32'h40B50533; in_pc = 32'h100; out_ready = 1;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid[0] !== 1'b1 || out_ALUCtrl[0] !== 4'd1 || out_srcBIn[0] !== 1'b0 ||
        out_regWrite[0] !== 1'b1 || out_rd[0] !== 5'd10 || out_pc[0] !== 32'h100) begin
      failures++; $display("FAIL sub valid=%b alu=%0d srcB=%b rw=%b rd=%0d pc=%h want 1/1/0/1/10/100",
        out_valid[0], out_ALUCtrl[0], out_srcBIn[0], out_regWrite[0], out_rd[0], out_pc[0]);
    end
    tick();
    checks++;
    if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL sub_drain valid=%b want 0", out_valid[0]); end
  endtask

  task automatic test_back_to_back();
    out_ready = 0; in_valid = 1;
    in_instr = 32'h00A00093; in_pc = 32'h200; tick();
    in_instr = 32'h0000A103; in_pc = 32'h204; tick();
    checks++;
    if (in_ready[0] !== 1'b0 || out_rd[0] !== 5'd1 || out_ALUCtrl[0] !== 4'd0) begin
      failures++; $display("FAIL b2b_full ready=%b rd=%0d alu=%0d want 0/1/0", in_ready[0], out_rd[0], out_ALUCtrl[0]);
    end
    in_instr = 32'h00112223; in_pc = 32'h208; tick();
    checks++;
    if (out_valid[0] !== 1'b1 || out_pc[0] !== 32'h200 || out_rd[0] !== 5'd1) begin
      failures++; $display("FAIL b2b_stall valid=%b pc=%h rd=%0d want 1/200/1", out_valid[0], out_pc[0], out_rd[0]);
    end
    out_ready = 1; tick();
    checks++;
    if (out_pc[0] !== 32'h204 || out_loadCtrl[0] !== 3'd2 || out_ALUCtrl[0] !== 4'd0 || out_resultSource[0] !== 2'd1) begin
      failures++; $display("FAIL b2b_load pc=%h load=%0d alu=%0d res=%0d want 204/2/0/1", out_pc[0], out_loadCtrl[0], out_ALUCtrl[0], out_resultSource[0]);
    end
    tick();
    in_valid = 0;
    checks++;
    if (out_pc[0] !== 32'h208 || out_storeCtrl[0] !== 2'd2 || out_memWrite[0] !== 1'b1 ||
        out_regWrite[0] !== 1'b0 || out_ALUCtrl[0] !== 4'd0 || out_loadCtrl[0] !== 3'd0) begin
      failures++; $display("FAIL b2b_store pc=%h st=%0d mw=%b rw=%b alu=%0d ld=%0d want 208/2/1/0/0/0",
        out_pc[0], out_storeCtrl[0], out_memWrite[0], out_regWrite[0], out_ALUCtrl[0], out_loadCtrl[0]);
    end
    tick();
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_drain valid=%b ready=%b want 0/1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_muldiv();
    in_valid = 1; in_instr = 32'h02A5C533; in_pc = 32'h300; out_ready = 1;
    tick();
    in_valid = 0;
    checks++;
    if (out_illegal[0] !== 1'b1 || out_regWrite[0] !== 1'b0 || out_isMulDiv[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
      failures++; $display("FAIL div_no_m ill=%b rw=%b md=%b valid=%b want 1/0/0/1", out_illegal[0], out_regWrite[0], out_isMulDiv[0], out_valid[0]);
    end
    checks++;
    if (out_illegal[1] !== 1'b0 || out_isMulDiv[1] !== 1'b1 || out_mulDivOp[1] !== 3'd4 || out_regWrite[1] !== 1'b1) begin
      failures++; $display("FAIL div_with_m ill=%b md=%b op=%0d rw=%b want 0/1/4/1", out_illegal[1], out_isMulDiv[1], out_mulDivOp[1], out_regWrite[1]);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1;
    in_instr = 32'h00A00093; in_pc = 32'h400; tick();
    in_instr = 32'h00B00113; in_pc = 32'h404; tick();
    flush = 1; in_instr = 32'h123450B7; in_pc = 32'h408;
    tick();
    flush = 0; in_valid = 0;
    checks++;
    if (out_valid[0] !== 1'b0 || out_valid[1] !== 1'b0 || in_ready[0] !== 1'b1) begin
      failures++; $display("FAIL flush_skid valid=%b/%b ready=%b want 0/0/1", out_valid[0], out_valid[1], in_ready[0]);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL flush_dropped cycle%0d valid=%b pc=%h want 0", i, out_valid[0], out_pc[0]); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] words [3] = '{32'h00000063, 32'h00002063, 32'h00003063};
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_instr = words[i]; in_pc = 32'h500 + 32'(4 * i);
      tick();
      in_valid = 0;
      checks++;
      if (i == 0) begin
        if (out_branch[0] !== 1'b1 || out_branchCond[0] !== 3'd0 || out_ALUCtrl[0] !== 4'd1 ||
            out_regWrite[0] !== 1'b0 || out_illegal[0] !== 1'b0 || out_immSource[0] !== 3'd2) begin
          failures++; $display("FAIL beq br=%b cond=%0d alu=%0d rw=%b ill=%b imm=%0d want 1/0/1/0/0/2",
            out_branch[0], out_branchCond[0], out_ALUCtrl[0], out_regWrite[0], out_illegal[0], out_immSource[0]);
        end
      end else if (out_illegal[0] !== 1'b1 || out_branch[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
        failures++; $display("FAIL branch_bad_f3 w=%h ill=%b br=%b valid=%b want 1/0/1", words[i], out_illegal[0], out_branch[0], out_valid[0]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bundle_t exp;
    for (int n = 0; n < 800; n++) begin
      in_valid = ($urandom_range(0, 9) < 7); in_instr = rand_instr(); in_pc = $urandom;
      out_ready = ($urandom_range(0, 9) < 6); flush = ($urandom_range(0, 24) == 0);
      tick();
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (out_valid[g] !== (q.size() > 0) || in_ready[g] !== (q.size() < 2)) begin
          failures++; $display("FAIL rand_handshake n=%0d dut%0d valid=%b ready=%b depth=%0d", n, g, out_valid[g], in_ready[g], q.size());
        end
        if (q.size() > 0) begin
          exp = ref_decode(q[0][63:32], q[0][31:0], g);
          checks++;
          if (obs(g) !== exp) begin
            failures++; $display("FAIL rand_bundle n=%0d dut%0d instr=%h got=%h want=%h", n, g, q[0][63:32], obs(g), exp);
          end
        end
      end
    end
    flush = 1; in_valid = 0; tick(); flush = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sub();
    test_back_to_back();
    test_muldiv();
    test_flush();
    test_branch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
